fft8_frame_ctrl: RTL
====================

// Module: fft8_frame_ctrl
// PURPOSE
//   Frame sequencer for the 3-stage pipelined 8-point FFT core (fft_top_8).
//   - Input side: collects 8 serial audio samples through a valid/ready stream.
//   - Core drive: presents the frame in parallel to the core's x_0..x_7 inputs and holds it stable.
//   - Capture: waits out the pipeline latency, then stores y_k_r/y_k_i in an output buffer.
//   - Output side: streams the 8 bins serially to the feature-extraction stage.
//   - Filling of the next frame overlaps draining of the previous one.
// PARAMETERS
//   DATA_W   12  sample and bin width (two's complement); matches the core
//   FFT_LAT  3   core latency in clock edges from stable x to valid y
// PORTS
//   clk        in   1         system clock, all logic on rising edge
//   rst        in   1         asynchronous reset, active-high
//   s_valid    in   1         input sample valid
//   s_ready    out  1         controller accepts a sample
//   s_data     in   DATA_W    input sample
//   fft_x      out  8*DATA_W  frame to core; x_k = fft_x[k*DATA_W +: DATA_W]
//   fft_y_r    in   8*DATA_W  core real outputs, same packing
//   fft_y_i    in   8*DATA_W  core imaginary outputs, same packing
//   m_valid    out  1         output bin valid
//   m_ready    in   1         downstream accepts a bin
//   m_re       out  DATA_W    bin real part
//   m_im       out  DATA_W    bin imaginary part
//   m_bin      out  3         bin index 0..7
//   m_last     out  1         high with bin 7
//   busy       out  1         any frame in WAIT or any bin undrained
// BEHAVIOUR
//   Reset (async, rst=1)
//   - Input FSM goes to FILL; wr_ptr=0. Output buffer is empty; rd_ptr=0.
//   - fft_x, m_re, m_im, m_bin, m_last, m_valid, busy are 0.
//   - s_ready becomes 1 on the first edge after rst deasserts.
//   - A reset mid-frame or mid-drain discards all data; there is no partial output.
//   Input FSM: FILL -> WAIT -> FILL
//   - FILL: s_ready=1. On s_valid&&s_ready, s_data is written to slot wr_ptr of fft_x and wr_ptr increments.
//     - On the beat with wr_ptr==7, wr_ptr wraps to 0, the FSM moves to WAIT and lat_cnt is cleared.
//   - WAIT: s_ready=0 and fft_x is frozen. lat_cnt increments each edge, saturating at FFT_LAT.
//     - The capture condition is lat_cnt==FFT_LAT && (out buffer empty || final drain beat this cycle).
//     - On capture: the out buffer loads all 16 fft_y words, the buffer becomes full, rd_ptr=0 and the FSM moves to FILL.
//   - Timing: the sample-7 accept edge is E0; capture happens at E(FFT_LAT+1), not earlier.
//     - m_valid=1 and s_ready=1 from E(FFT_LAT+1).
//   - If the out buffer is still draining, WAIT stalls indefinitely, with fft_x held and lat_cnt held at FFT_LAT.
//   Output side
//   - m_valid=1 whenever the buffer is full. m_re/m_im/m_bin show bin rd_ptr, in natural order 0..7.
//   - A beat is m_valid&&m_ready; it advances rd_ptr.
//   - After the beat on bin 7 the buffer becomes empty (m_valid=0 next cycle) unless a capture happens on the same edge.
//     - A same-edge capture reloads the buffer with rd_ptr=0, so m_valid stays 1 with no bubble.
//   - While m_valid=1 and m_ready=0, all m_* outputs are held stable; a valid is never withdrawn.
//   - m_last = m_valid && rd_ptr==7.
//   Arithmetic and status
//   - No arithmetic. Bins pass through bit-exact (core scaling is unchanged).
//   - busy = (state==WAIT) || buffer full.
// TESTING
//   - Reset then 8 beats s_data=1..8 back-to-back with m_ready=1 -> first m_valid exactly FFT_LAT+1 edges after the sample-8 edge.
//     m_re/m_im match the core's y_k_r/y_k_i for k=0..7. m_last only on bin 7. busy returns to 0 after bin 7.
//   - Impulse frame x=100,0,0,0,0,0,0,0 -> all 8 bins show the core's impulse response for input 100.
//     Also feed a constant x=10 frame (DC) and check against the core model.
//   - Continuous input with m_ready held 0 for 40 cycles:
//     - frame 2 fills during the stall, then WAIT stalls with s_ready=0;
//     - when m_ready is released, frame 1 drains bins 0..7 and frame 2 captures on the bin-7 beat edge with no m_valid gap;
//     - fft_x is unchanged throughout the stall.
//   - m_ready toggling 1,0,1,0 during drain -> each bin is presented exactly once, in order, held while m_ready=0.
//   - s_valid toggling randomly during FILL -> wr_ptr advances only on handshakes, and the frame content equals the accepted samples in order.
//   - rst asserted after 5 accepted samples, and again mid-drain at bin 3 -> all outputs are 0 immediately.
//     The next full frame produces correct bins 0..7 with no residue from the aborted frame.

Source files
------------

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer around the pipelined 8-point FFT core. Collects 8 serial samples,
// holds them on the core inputs through the pipeline latency, then streams the 8 bins out.
module fft8_frame_ctrl #(
    parameter int DATA_W  = 12,
    parameter int FFT_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    output logic [8*DATA_W-1:0] fft_x,
    input  logic [8*DATA_W-1:0] fft_y_r,
    input  logic [8*DATA_W-1:0] fft_y_i,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_re,
    output logic [DATA_W-1:0]   m_im,
    output logic [2:0]          m_bin,
    output logic                m_last,
    output logic                busy
);

    localparam logic [0:0]       ST_FILL = 1'b0;
    localparam logic [0:0]       ST_WAIT = 1'b1;
    localparam int               LAT_W   = (FFT_LAT < 1) ? 1 : $clog2(FFT_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(FFT_LAT);

    logic [0:0]             state_q,   state_d;
    logic [2:0]             wr_ptr_q,  wr_ptr_d;
    logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
    logic [7:0][DATA_W-1:0] x_q,       x_d;
    logic                   s_ready_q, s_ready_d;
    logic                   full_q,    full_d;
    logic [2:0]             rd_ptr_q,  rd_ptr_d;
    logic [7:0][DATA_W-1:0] yr_q,      yr_d;
    logic [7:0][DATA_W-1:0] yi_q,      yi_d;

    logic s_beat;
    logic m_beat;
    logic drain_done;
    logic lat_done;
    logic capture;

    assign s_beat     = s_valid && s_ready_q;
    assign m_beat     = full_q && m_ready;
    assign drain_done = m_beat && (rd_ptr_q == 3'd7);
    assign lat_done   = (lat_cnt_q == LAT_MAX);
    // A waiting frame may capture on the same edge the last bin leaves, so the stream has no bubble.
    assign capture    = (state_q == ST_WAIT) && lat_done && (!full_q || drain_done);

    always_comb begin
        // NOTE: every _d starts from its held value so no path through this block infers a latch.
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        lat_cnt_d = lat_cnt_q;
        x_d       = x_q;
        case (state_q)
            ST_FILL: begin
                if (s_beat) begin
                    x_d[wr_ptr_q] = s_data;
                    wr_ptr_d      = wr_ptr_q + 3'd1;
                    if (wr_ptr_q == 3'd7) begin
                        state_d   = ST_WAIT;
                        lat_cnt_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (!lat_done) begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
                if (capture) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
        s_ready_d = (state_d == ST_FILL);
    end

    always_comb begin
        full_d   = full_q;
        rd_ptr_d = rd_ptr_q;
        yr_d     = yr_q;
        yi_d     = yi_q;
        if (capture) begin
            yr_d     = fft_y_r;
            yi_d     = fft_y_i;
            full_d   = 1'b1;
            rd_ptr_d = 3'd0;
        end else if (m_beat) begin
            rd_ptr_d = rd_ptr_q + 3'd1;
            if (rd_ptr_q == 3'd7) begin
                full_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FILL;
            wr_ptr_q  <= 3'd0;
            lat_cnt_q <= '0;
            x_q       <= '0;
            s_ready_q <= 1'b0;
            full_q    <= 1'b0;
            rd_ptr_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            lat_cnt_q <= lat_cnt_d;
            x_q       <= x_d;
            s_ready_q <= s_ready_d;
            full_q    <= full_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // NOTE: bin storage has no reset; the m_* ports are masked by full_q, so stale bins never escape.
    always_ff @(posedge clk) begin
        yr_q <= yr_d;
        yi_q <= yi_d;
    end

    assign s_ready = s_ready_q;
    assign fft_x   = x_q;
    assign m_valid = full_q;
    assign m_re    = full_q ? yr_q[rd_ptr_q] : '0;
    assign m_im    = full_q ? yi_q[rd_ptr_q] : '0;
    assign m_bin   = full_q ? rd_ptr_q : 3'd0;
    assign m_last  = full_q && (rd_ptr_q == 3'd7);
    assign busy    = (state_q == ST_WAIT) || full_q;

endmodule
